vga_fetch: RTL and testbench

//  Bus master that streams the framebuffer to the VGA pixel pipeline. Drives the
//  VGA request side of the bus controller (address/read, reads back wait), writes

---
 rtl/vga_fetch.sv | 143 ++++++++++++++
 tb/tb_vga_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fetch.sv
`default_nettype none
// =============================================================================
// Module      : vga_fetch
// Description : Framebuffer bus master feeding a show-ahead pixel FIFO.
// Revision    : 1.0 - initial release
// =============================================================================
module vga_fetch #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LINE_WORDS = 160,
    parameter int          LINES      = 480,
    parameter int          FIFO_AW    = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] vga_address,
    output logic        vga_read,
    input  logic        vga_wait,
    input  logic [31:0] vga_readdata,
    input  logic        frame_start,
    input  logic        pix_pop,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    output logic        underrun,
    output logic        frame_done
);

    localparam int                 c_TOTAL = LINES * LINE_WORDS;
    localparam int                 c_IDX_W = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;
    localparam int                 c_DEPTH = 2 ** FIFO_AW;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(c_TOTAL - 1);
    localparam logic [FIFO_AW:0]   c_FULL  = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_push;
    logic                 w_pop;
    logic [c_IDX_W-1:0]   r_word_idx;
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic                 r_underrun;
    logic                 r_frame_done;
    logic [31:0]          r_mem [c_DEPTH];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_DONE;
        end else begin
            r_state <= w_next;
        end
    end

    // A frame restart abandons any open request through GAP so the bus
    // controller always sees read low for a cycle before the next request.
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        if (frame_start) begin
            w_next = (r_state == S_REQ) ? S_GAP : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < c_FULL) begin
                        w_next = S_REQ;
                    end
                end
                S_REQ: begin
                    if (!vga_wait) begin
                        w_push = 1'b1;
                        w_next = S_GAP;
                    end
                end
                S_GAP: begin
                    w_next = r_frame_done ? S_DONE : S_IDLE;
                end
                default: begin
                    w_next = r_state;
                end
            endcase
        end
    end

    assign w_pop = pix_pop && (r_count != '0) && !frame_start;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_word_idx   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_underrun   <= 1'b0;
            r_frame_done <= 1'b1;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (frame_start) begin
            r_word_idx   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_underrun   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= vga_readdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                if (r_word_idx == c_LAST) begin
                    r_word_idx   <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_word_idx <= r_word_idx + 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (pix_pop && (r_count == '0)) begin
                r_underrun <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign vga_read    = (r_state == S_REQ);
    assign vga_address = BASE_ADDR + 32'({r_word_idx, 2'b00});
    assign pix_data    = r_mem[r_rd_ptr];
    assign pix_valid   = (r_count != '0);
    assign underrun    = r_underrun;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_vga_fetch.sv
`default_nettype none
// =============================================================================
// Module      : tb_vga_fetch
// Description : Self-checking bench for vga_fetch with a queue-level reference.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_vga_fetch;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          LW    = 8;
    localparam int          LN    = 4;
    localparam int          TOTAL = LW * LN;
    localparam int          DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] vga_address;
    logic        vga_read;
    logic        vga_wait;
    logic [31:0] vga_readdata;
    logic        frame_start;
    logic        pix_pop;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        underrun;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    vga_fetch #(
        .BASE_ADDR (BASE),
        .LINE_WORDS(LW),
        .LINES     (LN),
        .FIFO_AW   (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .vga_address (vga_address),
        .vga_read    (vga_read),
        .vga_wait    (vga_wait),
        .vga_readdata(vga_readdata),
        .frame_start (frame_start),
        .pix_pop     (pix_pop),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underrun    (underrun),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: FIFO as a queue, addresses from the count of accepted words.
    logic [31:0] mq[$];
    int          m_acks  = 0;
    bit          m_done  = 1'b1;
    bit          m_und   = 1'b0;
    bit          m_quiet = 1'b1;
    bit          model_on = 1'b0;

    always @(posedge clock) begin
        bit push;
        bit pop;
        if (!reset_n) begin
            mq.delete();
            m_acks = 0; m_done = 1'b1; m_und = 1'b0; m_quiet = 1'b1; model_on = 1'b1;
        end else if (model_on) begin
            if (frame_start) begin
                mq.delete();
                m_acks = 0; m_done = 1'b0; m_und = 1'b0; m_quiet = 1'b1;
            end else begin
                push = vga_read && !vga_wait;
                pop  = pix_pop && (mq.size() > 0);
                if (pix_pop && mq.size() == 0) m_und = 1'b1;
                if (pop) void'(mq.pop_front());
                if (push) begin
                    mq.push_back(vga_readdata);
                    m_acks++;
                    if (m_acks == TOTAL) m_done = 1'b1;
                end
                m_quiet = push;
            end
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            check("m_valid", pix_valid, (mq.size() != 0));
            if (mq.size() != 0) check("m_data", pix_data, mq[0]);
            check("m_underrun", underrun, m_und);
            check("m_frame_done", frame_done, m_done);
            if (vga_read) check("m_addr", vga_address, BASE + 32'(m_acks) * 4);
            if (m_quiet || m_done || mq.size() >= DEPTH) check("m_read_low", vga_read, 1'b0);
        end
    end

    typedef struct {
        logic        fs;
        logic        wt;
        logic [31:0] rd;
        logic        pop;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_und;
        logic        e_done;
    } vec_t;

    function automatic vec_t mk(logic fs, logic wt, logic [31:0] rd, logic pop, logic e_read,
                                logic [31:0] e_addr, logic e_valid, logic [31:0] e_data,
                                logic e_und, logic e_done);
        vec_t v;
        v.fs = fs; v.wt = wt; v.rd = rd; v.pop = pop; v.e_read = e_read; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_data = e_data; v.e_und = e_und; v.e_done = e_done;
        return v;
    endfunction

    initial begin
        vec_t        tbl[16];
        logic [31:0] tail[5];
        int          n;
        int          acks;
        bit          ack;
        bit          found;

        tbl[0]  = mk(1, 1, 0, 0,            0, BASE,     0, 0,            0, 0);
        tbl[1]  = mk(0, 1, 0, 0,            1, BASE,     0, 0,            0, 0);
        tbl[2]  = mk(0, 1, 0, 0,            1, BASE,     0, 0,            0, 0);
        tbl[3]  = mk(0, 1, 0, 0,            1, BASE,     0, 0,            0, 0);
        tbl[4]  = mk(0, 1, 0, 0,            1, BASE,     0, 0,            0, 0);
        tbl[5]  = mk(0, 0, 32'hDEADBEEF, 0, 0, BASE + 4, 1, 32'hDEADBEEF, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0,            0, BASE + 4, 1, 32'hDEADBEEF, 0, 0);
        tbl[7]  = mk(0, 1, 0, 0,            1, BASE + 4, 1, 32'hDEADBEEF, 0, 0);
        tbl[8]  = mk(0, 1, 0, 1,            1, BASE + 4, 0, 0,            0, 0);
        tbl[9]  = mk(0, 1, 0, 1,            1, BASE + 4, 0, 0,            1, 0);
        tbl[10] = mk(0, 0, 32'h11111111, 0, 0, BASE + 8, 1, 32'h11111111, 1, 0);
        tbl[11] = mk(1, 1, 0, 0,            0, BASE,     0, 0,            0, 0);
        tbl[12] = mk(0, 1, 0, 0,            1, BASE,     0, 0,            0, 0);
        tbl[13] = mk(1, 0, 32'hBAD0BAD0, 0, 0, BASE,     0, 0,            0, 0);
        tbl[14] = mk(0, 1, 0, 0,            0, BASE,     0, 0,            0, 0);
        tbl[15] = mk(0, 1, 0, 0,            1, BASE,     0, 0,            0, 0);

        reset_n = 1'b0; vga_wait = 1'b1; vga_readdata = '0; frame_start = 1'b0; pix_pop = 1'b0;
        repeat (3) step();
        check("rst_read", vga_read, 1'b0);
        check("rst_addr", vga_address, BASE);
        check("rst_valid", pix_valid, 1'b0);
        check("rst_data", pix_data, 32'h0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_done", frame_done, 1'b1);
        reset_n = 1'b1;
        repeat (3) step();
        check("idle_before_start", vga_read, 1'b0);

        // First request latency, underrun, restart mid-request.
        for (int i = 0; i < 16; i++) begin
            frame_start = tbl[i].fs; vga_wait = tbl[i].wt; vga_readdata = tbl[i].rd; pix_pop = tbl[i].pop;
            step();
            check($sformatf("vec%0d_read", i), vga_read, tbl[i].e_read);
            check($sformatf("vec%0d_addr", i), vga_address, tbl[i].e_addr);
            check($sformatf("vec%0d_valid", i), pix_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) check($sformatf("vec%0d_data", i), pix_data, tbl[i].e_data);
            check($sformatf("vec%0d_underrun", i), underrun, tbl[i].e_und);
            check($sformatf("vec%0d_done", i), frame_done, tbl[i].e_done);
        end
        frame_start = 1'b0; pix_pop = 1'b0;

        // Fill to full with no consumer.
        vga_wait = 1'b0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            vga_readdata = 32'h100 + 32'(n);
            ack = vga_read;
            step();
            if (ack) n++;
        end
        check("fill_words", 32'(n), 32'd16);
        check("full_read_low", vga_read, 1'b0);
        check("full_head", pix_data, 32'h100);

        vga_wait = 1'b1; pix_pop = 1'b1;
        step();
        pix_pop = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (vga_read) found = 1'b1;
            else step();
        end
        check("refill_request", found, 1'b1);
        check("refill_addr", vga_address, BASE + 32'h40);

        // Drain to five words, then push and pop together.
        pix_pop = 1'b1;
        repeat (10) step();
        pix_pop = 1'b0;
        check("five_head", pix_data, 32'h10B);
        vga_wait = 1'b0; pix_pop = 1'b1; vga_readdata = 32'hABCD0001;
        step();
        vga_wait = 1'b1; pix_pop = 1'b0;
        tail[0] = 32'h10C; tail[1] = 32'h10D; tail[2] = 32'h10E; tail[3] = 32'h10F; tail[4] = 32'hABCD0001;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("tail%0d_valid", k), pix_valid, 1'b1);
            check($sformatf("tail%0d_data", k), pix_data, tail[k]);
            pix_pop = 1'b1;
            step();
            pix_pop = 1'b0;
        end
        check("tail_empty", pix_valid, 1'b0);

        // Whole frame with a steady consumer.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0; pix_pop = 1'b1; acks = 0;
        for (int c = 0; c < 1000 && !frame_done; c++) begin
            vga_wait = 1'($urandom_range(0, 1));
            vga_readdata = $urandom;
            if (vga_read && !vga_wait) acks++;
            step();
        end
        check("frame_done_reached", frame_done, 1'b1);
        check("frame_words", 32'(acks), 32'(TOTAL));
        vga_wait = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            check("done_read_low", vga_read, 1'b0);
        end
        pix_pop = 1'b0;

        // Random traffic, restarts and resets against the queue model.
        for (int c = 0; c < 4000; c++) begin
            reset_n      = ($urandom_range(0, 599) != 0);
            frame_start  = ($urandom_range(0, 199) == 0);
            vga_wait     = ($urandom_range(0, 2) == 0);
            vga_readdata = $urandom;
            pix_pop      = 1'($urandom_range(0, 1));
            step();
        end
        reset_n = 1'b1; frame_start = 1'b0; pix_pop = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
